cam_line_packer: RTL and testbench

Downstream of the camera capture stage. Consumes the 16-bit BGR565 pixel stream (vsync/de/pixel) in the half pixel-clock domain and packs pixel pairs into 32-bit words. Each line gets a header word carrying the frame id and line index. Words are written into the UDP payload FIFO, with start/end-of-line marks and sticky error flags for the packetizer.

---
 rtl/cam_line_packer.sv | 256 +++++++++++++++++++++++++
 tb/tb_cam_line_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_line_packer.sv
// Packs a BGR565 pixel stream into 32-bit FIFO words with a per-line header.
// Build option CAM_PACK_CHECKSUM_EN adds a per-line checksum trailer word.
module cam_line_packer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vsync,
    input  logic        de,
    input  logic [15:0] pix_data,
    output logic [31:0] out_data,
    output logic        out_wr,
    output logic        out_sol,
    output logic        out_eol,
    input  logic        out_full,
    output logic [7:0]  frame_id,
    output logic        frame_done,
    input  logic        err_clr,
    output logic        err_ovf,
    output logic        err_len,
    output logic        err_lines,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        LINE      = 2'd2,
        DROP      = 2'd3
    } state_t;

    localparam logic [15:0] H_LEN  = 16'(H_ACTIVE);
    localparam logic [15:0] V_LEN  = 16'(V_ACTIVE);
    localparam logic [15:0] V_LAST = 16'(V_ACTIVE - 1);

    state_t      state;
    state_t      state_next;

    logic        vs_r;
    logic        vs_r2;
    logic        de_q;
    logic [7:0]  frame_cnt;
    logic [15:0] line_idx;
    logic [15:0] pix_cnt;
    logic [15:0] pend;
    logic        eol_q;

    logic        frame_start;
    logic        start_frame;
    logic        de_rise;
    logic        line_first;
    logic        pix_in_line;
    logic        pair_done;
    logic        line_end;
    logic        abort;
    logic        last_line;

    logic        hdr_due;
    logic        pair_due;
    logic        flush_due;
    logic        trl_due;
    logic        any_due;
    logic        ovf_set;
    logic        len_set;
    logic        lines_set;

    logic        wr_next;
    logic        sol_next;
    logic        eol_next;
    logic [31:0] data_next;

`ifdef CAM_PACK_CHECKSUM_EN
    logic [15:0] sum;
    logic        trl_pend;
`else
    logic        pair_q;
    logic        pair_next;
`endif

    assign state_dbg   = state;
    assign frame_start = (vs_r == VSYNC_POL) && (vs_r2 != VSYNC_POL);
    assign start_frame = frame_start && enable;
    assign de_rise     = de && !de_q;
    assign line_first  = (state == WAIT_LINE) && !frame_start && de_rise;
    assign pix_in_line = (state == LINE) && !frame_start && de;
    assign pair_done   = pix_in_line && pix_cnt[0];
    assign line_end    = ((state == LINE) || (state == DROP)) && !frame_start && !de;
    assign abort       = ((state == LINE) || (state == DROP)) && frame_start;
    assign last_line   = (line_idx == V_LAST);

    // Horizontal blanking is assumed to be at least two cycles so the
    // flush/trailer words never collide with the next line's header.
    assign hdr_due   = line_first;
    assign pair_due  = pair_done;
    assign flush_due = (state == LINE) && line_end && pix_cnt[0];
`ifdef CAM_PACK_CHECKSUM_EN
    assign trl_due   = ((state == LINE) && line_end && !pix_cnt[0]) || (trl_pend && !frame_start);
`else
    assign trl_due   = 1'b0;
`endif
    assign any_due   = hdr_due || pair_due || flush_due || trl_due;
    assign ovf_set   = any_due && out_full;
    assign len_set   = abort || (line_end && (pix_cnt != H_LEN));
    assign lines_set = (state == IDLE) && !frame_start && de_rise && (line_idx >= V_LEN);

    // FIFO handshake: out_wr is a one-cycle write strobe qualified by the
    // out_full seen in the cycle the write is decided; a write decided while
    // out_full=1 is dropped here and the rest of the line is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = enable ? WAIT_LINE : IDLE;
        end else begin
            case (state)
                WAIT_LINE: begin
                    if (line_first) state_next = out_full ? DROP : LINE;
                end
                LINE: begin
                    if (!de) state_next = last_line ? IDLE : WAIT_LINE;
                    else if (pair_done && out_full) state_next = DROP;
                end
                DROP: begin
                    if (!de) state_next = last_line ? IDLE : WAIT_LINE;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        wr_next   = 1'b0;
        sol_next  = 1'b0;
        eol_next  = 1'b0;
        data_next = 32'h0;
`ifndef CAM_PACK_CHECKSUM_EN
        pair_next = 1'b0;
`endif
        if (!out_full) begin
            if (hdr_due) begin
                wr_next   = 1'b1;
                sol_next  = 1'b1;
                data_next = {8'hA5, frame_id, line_idx};
            end else if (pair_due) begin
                wr_next   = 1'b1;
                data_next = {pix_data, pend};
`ifndef CAM_PACK_CHECKSUM_EN
                pair_next = 1'b1;
`endif
            end else if (flush_due) begin
                wr_next   = 1'b1;
                data_next = {16'h0000, pend};
`ifndef CAM_PACK_CHECKSUM_EN
                eol_next  = 1'b1;
`endif
            end else if (trl_due) begin
                wr_next   = 1'b1;
                eol_next  = 1'b1;
`ifdef CAM_PACK_CHECKSUM_EN
                data_next = {8'h5A, 8'h00, sum};
`endif
            end
        end
    end

`ifdef CAM_PACK_CHECKSUM_EN
    assign out_eol = eol_q;
`else
    // An even-length line only ends once de is seen low, which is the same
    // cycle its last pair word is on the bus, so that eol is combinational.
    assign out_eol = eol_q || (pair_q && (state == LINE) && line_end);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r       <= !VSYNC_POL;
            vs_r2      <= !VSYNC_POL;
            de_q       <= 1'b0;
            frame_cnt  <= 8'h00;
            frame_id   <= 8'h00;
            line_idx   <= 16'h0000;
            pix_cnt    <= 16'h0000;
            pend       <= 16'h0000;
            out_wr     <= 1'b0;
            out_sol    <= 1'b0;
            out_data   <= 32'h0;
            eol_q      <= 1'b0;
            frame_done <= 1'b0;
            err_ovf    <= 1'b0;
            err_len    <= 1'b0;
            err_lines  <= 1'b0;
        end else begin
            vs_r       <= vsync;
            vs_r2      <= vs_r;
            de_q       <= de;
            out_wr     <= wr_next;
            out_sol    <= sol_next;
            out_data   <= data_next;
            eol_q      <= eol_next;
            frame_done <= line_end && last_line;

            if (start_frame) begin
                frame_id  <= frame_cnt;
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (frame_start) line_idx <= 16'h0000;
            else if (line_end) line_idx <= line_idx + 16'd1;

            if (line_first) begin
                pix_cnt <= 16'd1;
            end else if (((state == LINE) || (state == DROP)) && !frame_start && de
                         && (pix_cnt != 16'hFFFF)) begin
                pix_cnt <= pix_cnt + 16'd1;
            end

            if (line_first || (pix_in_line && !pix_cnt[0])) pend <= pix_data;

            err_ovf   <= ovf_set   || (err_ovf   && !err_clr);
            err_len   <= len_set   || (err_len   && !err_clr);
            err_lines <= lines_set || (err_lines && !err_clr);
        end
    end

`ifdef CAM_PACK_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= 16'h0000;
            trl_pend <= 1'b0;
        end else begin
            trl_pend <= flush_due && !out_full;
            if (line_first) sum <= pix_data;
            else if (pix_in_line) sum <= sum + pix_data;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q <= 1'b0;
        end else begin
            pair_q <= pair_next;
        end
    end
`endif

endmodule

// File: tb/tb_cam_line_packer.sv
// Directed bench for cam_line_packer: small frame geometry, captured FIFO
// writes compared line by line against hand-built expected words.
module tb_cam_line_packer;
    localparam int H  = 16;
    localparam int V  = 12;
    localparam int BL = 4;
`ifdef CAM_PACK_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic        out_full = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] out_data;
    logic        out_wr;
    logic        out_sol;
    logic        out_eol;
    logic [7:0]  frame_id;
    logic        frame_done;
    logic        err_ovf;
    logic        err_len;
    logic        err_lines;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    cam_line_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync), .de(de),
        .pix_data(pix_data), .out_data(out_data), .out_wr(out_wr),
        .out_sol(out_sol), .out_eol(out_eol), .out_full(out_full),
        .frame_id(frame_id), .frame_done(frame_done), .err_clr(err_clr),
        .err_ovf(err_ovf), .err_len(err_len), .err_lines(err_lines),
        .state_dbg(state_dbg)
    );

    logic [31:0] mon_q[$];
    logic [1:0]  mon_f[$];
    logic [31:0] exp_q[$];
    logic [1:0]  exp_f[$];
    int          checks = 0;
    int          failures = 0;
    int          fd_cnt = 0;
    logic [31:0] first_word;
    logic [31:0] last_word;
    logic [31:0] last_hdr;

    always @(negedge clk) begin
        if (out_wr) begin
            mon_q.push_back(out_data);
            mon_f.push_back({out_sol, out_eol});
        end
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] pix_val(input int i, input int mode);
        return (mode == 1) ? 16'd3 : 16'(i);
    endfunction

    task automatic frame_sync();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        cyc(3);
    endtask

    task automatic drive_line(input int n, input int mode, input int fw);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            pix_data = pix_val(i, mode);
            out_full = (fw >= 0) && (i == 2 * fw + 1);
            cyc();
        end
        de = 1'b0;
        out_full = 1'b0;
        pix_data = 16'h0;
        cyc(BL);
    endtask

    // fw >= 0 means words from index fw on are absent and the line has no eol.
    task automatic expect_line(input int fid, input int lidx, input int n, input int mode, input int fw);
        int nw;
        logic [15:0] lo, hi, sum;
        exp_q.delete();
        exp_f.delete();
        exp_q.push_back({8'hA5, 8'(fid), 16'(lidx)});
        exp_f.push_back(2'b10);
        nw = (n + 1) / 2;
        sum = 16'h0;
        for (int i = 0; i < n; i++) sum = sum + pix_val(i, mode);
        for (int w = 0; w < nw; w++) begin
            if (!(fw >= 0 && w >= fw)) begin
                lo = pix_val(2 * w, mode);
                hi = (2 * w + 1 < n) ? pix_val(2 * w + 1, mode) : 16'h0;
                exp_q.push_back({hi, lo});
                exp_f.push_back({1'b0, (!CK && fw < 0 && w == nw - 1)});
            end
        end
        if (CK && fw < 0) begin
            exp_q.push_back({8'h5A, 8'h00, sum});
            exp_f.push_back(2'b01);
        end
    endtask

    task automatic compare_line(input string tag);
        int idx;
        logic [31:0] d;
        logic [1:0] f;
        idx = 0;
        chk({tag, "_count"}, mon_q.size(), exp_q.size());
        while (exp_q.size() > 0 && mon_q.size() > 0) begin
            d = mon_q.pop_front();
            f = mon_f.pop_front();
            if (f[1]) last_hdr = d;
            if (idx == 1) first_word = d;
            last_word = d;
            chk({tag, "_data"}, d, exp_q.pop_front());
            chk({tag, "_flags"}, {30'h0, f}, {30'h0, exp_f.pop_front()});
            idx++;
        end
        mon_q.delete();
        mon_f.delete();
        exp_q.delete();
        exp_f.delete();
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_wr", {31'h0, out_wr}, 32'h0);
        chk("rst_sol", {31'h0, out_sol}, 32'h0);
        chk("rst_eol", {31'h0, out_eol}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_fid", {24'h0, frame_id}, 32'h0);
        chk("rst_errs", {29'h0, err_ovf, err_len, err_lines}, 32'h0);
        chk("rst_state", {30'h0, state_dbg}, 32'h0);
        rst_n = 1'b1;
        enable = 1'b1;
        cyc(2);

        // Frame 0: clean frame, pixel value = column
        frame_sync();
        for (int l = 0; l < V; l++) begin
            drive_line(H, 0, -1);
            expect_line(0, l, H, 0, -1);
            compare_line("f0");
            if (l == 0) chk("f0_word0", first_word, 32'h0001_0000);
        end
`ifdef CAM_PACK_CHECKSUM_EN
        chk("f0_trailer", last_word, 32'h5A00_0078);
`else
        chk("f0_lastword", last_word, 32'h000F_000E);
`endif
        cyc(2);
        chk("f0_done", fd_cnt, 1);
        chk("f0_errs", {29'h0, err_ovf, err_len, err_lines}, 32'h0);
        chk("f0_fid", {24'h0, frame_id}, 32'h0);
        chk("f0_idle", {30'h0, state_dbg}, 32'h0);

        // Frame 1: FIFO full for one cycle at word 3 of line 3
        frame_sync();
        for (int l = 0; l < V; l++) begin
            drive_line(H, 0, (l == 3) ? 3 : -1);
            expect_line(1, l, H, 0, (l == 3) ? 3 : -1);
            compare_line("f1");
        end
        chk("f1_ovf", {31'h0, err_ovf}, 32'h1);
        chk("f1_len", {31'h0, err_len}, 32'h0);
        chk("f1_done", fd_cnt, 2);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("f1_ovf_clr", {31'h0, err_ovf}, 32'h0);

        // Frame 2: odd-length first line, header check on line 5
        frame_sync();
        for (int l = 0; l < V; l++) begin
            drive_line((l == 0) ? H + 1 : H, 0, -1);
            expect_line(2, l, (l == 0) ? H + 1 : H, 0, -1);
            compare_line("f2");
`ifdef CAM_PACK_CHECKSUM_EN
            if (l == 0) chk("f2_short_trailer", last_word, 32'h5A00_0088);
`else
            if (l == 0) chk("f2_short_flush", last_word, 32'h0000_0010);
`endif
            if (l == 5) chk("f2_l5_hdr", last_hdr, 32'hA502_0005);
        end
        chk("f2_len", {31'h0, err_len}, 32'h1);
        chk("f2_done", fd_cnt, 3);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("f2_len_clr", {31'h0, err_len}, 32'h0);

        // Frame 3: two lines beyond V are ignored
        frame_sync();
        for (int l = 0; l < V + 2; l++) begin
            drive_line(H, 0, -1);
            if (l < V) expect_line(3, l, H, 0, -1);
            compare_line("f3");
        end
        chk("f3_lines", {31'h0, err_lines}, 32'h1);
        chk("f3_len", {31'h0, err_len}, 32'h0);
        chk("f3_done", fd_cnt, 4);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("f3_lines_clr", {31'h0, err_lines}, 32'h0);

        // Frame 4: vsync arrives during line 10
        frame_sync();
        for (int l = 0; l < 10; l++) begin
            drive_line(H, 0, -1);
            expect_line(4, l, H, 0, -1);
            compare_line("f4");
        end
        for (int i = 0; i < 8; i++) begin
            de = 1'b1;
            pix_data = 16'(i);
            if (i == 5) vsync = 1'b1;
            cyc();
        end
        de = 1'b0;
        vsync = 1'b0;
        pix_data = 16'h0;
        cyc(BL);
        expect_line(4, 10, 8, 0, 3);
        compare_line("abort");
        chk("abort_len", {31'h0, err_len}, 32'h1);
        chk("abort_fid", {24'h0, frame_id}, 32'h5);
        chk("abort_state", {30'h0, state_dbg}, 32'h1);
        chk("abort_done", fd_cnt, 4);

        // Frame 5 line 0: constant pixels
        drive_line(H, 1, -1);
        expect_line(5, 0, H, 1, -1);
        compare_line("f5");
        chk("f5_hdr", last_hdr, 32'hA505_0000);
`ifdef CAM_PACK_CHECKSUM_EN
        chk("f5_trailer", last_word, 32'h5A00_0030);
`else
        chk("f5_lastword", last_word, 32'h0003_0003);
`endif

        // Reset in the middle of a line
        for (int i = 0; i < 3; i++) begin
            de = 1'b1;
            pix_data = 16'(i);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_wr", {31'h0, out_wr}, 32'h0);
        chk("midrst_fid", {24'h0, frame_id}, 32'h0);
        chk("midrst_len", {31'h0, err_len}, 32'h0);
        chk("midrst_state", {30'h0, state_dbg}, 32'h0);
        mon_q.delete();
        mon_f.delete();
        de = 1'b0;
        cyc(4);
        rst_n = 1'b1;
        cyc(4);
        chk("midrst_nowr", mon_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
